// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: frame geometry, register addresses and FSM states for spi_reg_peripheral.
package spi_reg_pkg;
    localparam int FRAME_BITS = 16;
    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop pin synchronizer with rise/fall pulses on the synchronized value.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= o_q;
        end
    end
    assign o_q    = r_sync[SYNC_STAGES-1];
    assign o_rise = o_q & ~r_prev;
    assign o_fall = ~o_q & r_prev;
endmodule

// File: rtl/spi_reg_peripheral.sv
// spi_reg_peripheral: SPI mode-0 write-only register bank (five 8-bit control registers).
// Define SPI_READBACK_EN to add the cipo port and read frames.
module spi_reg_peripheral
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
`ifdef SPI_READBACK_EN
    ,
    output logic       cipo
`endif
);
    state_t                 r_state, w_next;
    logic                   w_sclk_q, w_sclk_rise, w_sclk_fall;
    logic                   w_ncs_q, w_ncs_rise, w_ncs_fall;
    logic [SYNC_STAGES-1:0] r_copi_sync;
    logic [SYNC_STAGES:0]   r_vld;
    logic                   r_armed;
    logic [15:0]            r_shift;
    logic [4:0]             r_cnt;
    logic [7:0]             r_out_lo, r_out_hi, r_pwm_lo, r_pwm_hi, r_duty;
    logic                   w_copi, w_start, w_shift_en, w_wr, w_unused;
    logic [6:0]             w_addr;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .i_d(sclk), .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
        .clk(clk), .rst(rst), .i_d(ncs), .o_q(w_ncs_q), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
    );

    always_ff @(posedge clk) begin
        r_copi_sync <= rst ? '0 : {r_copi_sync[SYNC_STAGES-2:0], copi};
    end
    assign w_copi = r_copi_sync[SYNC_STAGES-1];

    // r_vld marks when the ncs synchronizer holds real pin samples rather than reset values
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld   <= '0;
            r_armed <= 1'b0;
        end else begin
            r_vld   <= {r_vld[SYNC_STAGES-1:0], 1'b1};
            r_armed <= r_armed | (r_vld[SYNC_STAGES] & w_ncs_q);
        end
    end

    assign w_start    = r_armed & w_ncs_fall;
    assign w_shift_en = (r_state == SHIFT) && w_sclk_rise && !w_ncs_rise;
    assign w_addr     = r_shift[14:8];
    assign w_wr       = (r_state == COMMIT) && r_cnt == 5'(FRAME_BITS) && r_shift[15] && w_addr <= 7'(MAX_ADDR);

    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_next;
    end

    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE)  ? (w_start ? SHIFT : IDLE) :
                 (r_state == SHIFT) ? (w_ncs_rise ? COMMIT : SHIFT) : IDLE;
    end

    // counter saturates one past a full frame so long frames stay rejected
    always_ff @(posedge clk) begin
        if (rst || (r_state == IDLE && w_start)) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_shift_en) begin
            r_shift <= {r_shift[14:0], w_copi};
            r_cnt   <= (r_cnt == 5'(FRAME_BITS + 1)) ? r_cnt : r_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_lo <= '0;
            r_out_hi <= '0;
            r_pwm_lo <= '0;
            r_pwm_hi <= '0;
            r_duty   <= '0;
        end else begin
            r_out_lo <= (w_wr && w_addr == ADDR_EN_OUT_LO) ? r_shift[7:0] : r_out_lo;
            r_out_hi <= (w_wr && w_addr == ADDR_EN_OUT_HI) ? r_shift[7:0] : r_out_hi;
            r_pwm_lo <= (w_wr && w_addr == ADDR_EN_PWM_LO) ? r_shift[7:0] : r_pwm_lo;
            r_pwm_hi <= (w_wr && w_addr == ADDR_EN_PWM_HI) ? r_shift[7:0] : r_pwm_hi;
            r_duty   <= (w_wr && w_addr == ADDR_PWM_DUTY)  ? r_shift[7:0] : r_duty;
        end
    end

    assign en_reg_out_7_0  = r_out_lo;
    assign en_reg_out_15_8 = r_out_hi;
    assign en_reg_pwm_7_0  = r_pwm_lo;
    assign en_reg_pwm_15_8 = r_pwm_hi;
    assign pwm_duty_cycle  = r_duty;

`ifdef SPI_READBACK_EN
    logic [7:0] r_tx, w_rd_val;
    logic [6:0] w_hdr_addr;
    logic       w_load;
    assign w_hdr_addr = {r_shift[5:0], w_copi};
    assign w_load     = w_shift_en && r_cnt == 5'd7 && !r_shift[6] && w_hdr_addr <= 7'(MAX_ADDR);
    assign w_rd_val   = (w_hdr_addr == ADDR_EN_OUT_LO) ? r_out_lo :
                        (w_hdr_addr == ADDR_EN_OUT_HI) ? r_out_hi :
                        (w_hdr_addr == ADDR_EN_PWM_LO) ? r_pwm_lo :
                        (w_hdr_addr == ADDR_EN_PWM_HI) ? r_pwm_hi :
                        (w_hdr_addr == ADDR_PWM_DUTY)  ? r_duty   : 8'h00;
    // the falling edge right after the last header bit keeps the MSB on the line
    always_ff @(posedge clk) begin
        if (rst || r_state != SHIFT)
            r_tx <= '0;
        else if (w_load)
            r_tx <= w_rd_val;
        else if (w_sclk_fall && r_cnt > 5'd8)
            r_tx <= {r_tx[6:0], 1'b0};
    end
    assign cipo     = r_tx[7];
    assign w_unused = w_sclk_q;
`else
    assign w_unused = ^{w_sclk_q, w_sclk_fall};
`endif
endmodule

// File: tb/tb_spi_reg_peripheral.sv
// tb_spi_reg_peripheral: directed and random SPI frames checked against a register-array model.
module tb_spi_reg_peripheral;
    logic       clk = 1'b0;
    logic       rst, sclk, copi, ncs;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
`ifdef SPI_READBACK_EN
    logic       cipo;
`endif
    logic [7:0] model [5];
    int         n_err = 0;
    int         n_chk = 0;

    spi_reg_peripheral dut (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle)
`ifdef SPI_READBACK_EN
        , .cipo(cipo)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, "/out_lo"}, en_reg_out_7_0, model[0]);
        check({tag, "/out_hi"}, en_reg_out_15_8, model[1]);
        check({tag, "/pwm_lo"}, en_reg_pwm_7_0, model[2]);
        check({tag, "/pwm_hi"}, en_reg_pwm_15_8, model[3]);
        check({tag, "/duty"}, pwm_duty_cycle, model[4]);
    endtask

    // sclk half period of 5 clk; bits beyond 16 are random filler
    task automatic shift_bits(input logic [15:0] w, input int n, output logic [7:0] rd);
        rd = 8'h00;
        for (int i = 0; i < n; i++) begin
            copi = (i < 16) ? w[15-i] : 1'($urandom);
            repeat (5) @(negedge clk);
`ifdef SPI_READBACK_EN
            if (i >= 8 && i < 16) rd = {rd[6:0], cipo};
`endif
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    // live=0 means the DUT is expected to ignore the frame entirely
    task automatic frame(input logic [15:0] w, input int n, input bit live);
        logic [7:0] rd, exp_rd;
        exp_rd = (!w[15] && w[14:8] <= 7'd4) ? model[w[10:8]] : 8'h00;
        @(negedge clk);
        ncs = 1'b0;
        repeat (5) @(negedge clk);
        shift_bits(w, n, rd);
        repeat (5) @(negedge clk);
        ncs = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        if (live && n == 16 && w[15] && w[14:8] <= 7'd4) model[w[10:8]] = w[7:0];
`ifdef SPI_READBACK_EN
        if (live && n >= 16) check("cipo", rd, exp_rd);
`else
        if (rd != exp_rd) rd = exp_rd;
`endif
    endtask

    initial begin
        logic [7:0] dummy;
        int nsel [5] = '{15, 16, 16, 16, 17};
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b0;
        repeat (3) @(negedge clk);
        check_regs("reset");
        rst = 1'b0;
        frame(16'h80A5, 16, 1'b0);
        check_regs("no_arm");
        frame(16'h80A5, 16, 1'b1);
        check_regs("wr0");
        frame(16'h8111, 16, 1'b1);
        frame(16'h8222, 16, 1'b1);
        frame(16'h8333, 16, 1'b1);
        frame(16'h8480, 16, 1'b1);
        check_regs("wr1to4");
        frame(16'h85FF, 16, 1'b1);
        check_regs("addr5");
        frame(16'h825A, 15, 1'b1);
        check_regs("short");
        frame(16'h825A, 17, 1'b1);
        check_regs("long");
        for (int i = 0; i < 16; i++) begin
            copi = 1'($urandom);
            repeat (5) @(negedge clk);
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (8) @(negedge clk);
        check_regs("sclk_idle");
        frame(16'h0400, 16, 1'b1);
        check_regs("read");
        ncs = 1'b0;
        repeat (5) @(negedge clk);
        shift_bits(16'h8155, 9, dummy);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        check_regs("rst_mid");
        shift_bits(16'h5555, 7, dummy);
        repeat (5) @(negedge clk);
        ncs = 1'b1;
        repeat (8) @(negedge clk);
        check_regs("rst_tail");
        frame(16'h833C, 16, 1'b1);
        check_regs("after_rst");
        for (int k = 0; k < 40; k++) begin
            logic [15:0] w;
            w = {($urandom_range(0, 3) != 0), 7'($urandom_range(0, 6)), 8'($urandom)};
            frame(w, nsel[$urandom_range(0, 4)], 1'b1);
            check_regs("rand");
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
